control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  system clock; all state changes on rising edge.
REQ-002 clear  in  1  asynchronous, active-high reset.
REQ-003 IR  in  32  instruction register contents from datapath; opcode = IR[31:27].
REQ-004 CON  in  1  branch-condition flag from datapath CON flip-flop.
REQ-005 opcode  out  5  ALU operation select to datapath.
REQ-006 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select/enable to datapath select-encode logic.
REQ-007 PCin, IRin, MARin, MDRin, Yin, Zin, CONin, HIin, LOin  out  1 each  register load enables.
REQ-008 PCout, MDRout, Zlowout, Zhighout, Cout, HIout, LOout  out  1 each  bus drive enables.
REQ-009 Read, Write, IncPC  out  1 each  memory read/write strobes, PC increment.
REQ-010 Run  out  1  high while processor executes; low after HALT.

Function
REQ-011 Moore FSM, one state per clock; outputs decoded from the registered state only, held for the full cycle.
REQ-012 States: RST, T0..T7, HLT; any output not listed for a state SHALL be 0; opcode SHALL be 5'b00000 unless listed.
REQ-013 RST: all outputs 0, Run=1; next state T0.
REQ-014 T0: PCout, MARin, IncPC, Zin. T1: Zlowout, PCin, Read, MDRin. T2: MDRout, IRin.
REQ-015 After T2 decode IR[31:27]: LD 00000, LDI 00001, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, ADDI 01100, BR 10010, NOP 11010, HALT 11011.
REQ-016 ADD/SUB/AND/OR: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, opcode=IR opcode; T5 Zlowout,Gra,Rin; then T0 (6 cycles).
REQ-017 ADDI: T3 Grb,Rout,Yin; T4 Cout,Zin,opcode=00011; T5 Zlowout,Gra,Rin; then T0.
REQ-018 LDI: T3 Grb,BAout,Yin; T4 Cout,Zin,opcode=00011; T5 Zlowout,Gra,Rin; then T0.
REQ-019 LD: T3-T4 as LDI; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; then T0 (8 cycles).
REQ-020 ST: T3-T5 as LD; T6 Gra,Rout,MDRin (Read=0); T7 Write; then T0.
REQ-021 BR: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,opcode=00011; T6 Zlowout and PCin SHALL assert only if CON=1 (sampled in T6); then T0.
REQ-022 NOP and any undefined opcode: T2 -> T0, no side effects.
REQ-023 HALT: T2 -> HLT; HLT holds indefinitely, all outputs 0, Run=0; only clear exits.
REQ-024 Read and Write SHALL never assert in the same cycle.

Reset
REQ-025 clear=1 forces RST immediately, independent of Clock, mid-instruction included; all outputs 0 and Run=1 within the same cycle.
REQ-026 First rising edge with clear=0 moves RST -> T0.

Configuration
REQ-027 Macro CU_BRANCH_EN defined: BR executes per REQ-021.
REQ-028 Macro CU_BRANCH_EN undefined: BR decodes as NOP (T2 -> T0); CONin never asserted.

Structure
REQ-029 Package cpu_pkg holds opcode constants and the FSM state enumeration.
REQ-030 One sub-module, control_decode: purely combinational state+IR+CON -> control outputs; control_unit holds the state register and next-state logic.

Verification
REQ-031 clear pulse during ADD T4 -> all outputs 0 at once; T0 signals on first edge after RST.
REQ-032 IR opcode 00011 -> states T0..T5, T4 opcode=00011 with Grc,Rout,Zin; back to T0 on cycle 7.
REQ-033 IR opcode 00000 -> T5 Zlowout+MARin, T6 Read+MDRin, T7 MDRout+Gra+Rin; 8-cycle period.
REQ-034 IR opcode 00010 -> T6 MDRin with Read=0, T7 Write=1; Read&Write never both 1 across run.
REQ-035 IR opcode 10010, CON=0 then CON=1 -> T6 PCin=0 then PCin=1; with CU_BRANCH_EN undefined -> T2 -> T0.
REQ-036 IR opcode 11011 -> HLT, Run=0 for 20 cycles; clear -> Run=1, fetch resumes at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcode constants, FSM states,
// instruction classes and the control-word struct.
// Optional feature macro: CU_BRANCH_EN (when undefined, BR executes as a NOP).
package cpu_pkg;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpBr   = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHlt
  } state_e;

  typedef enum logic [2:0] {
    ClsNop, ClsAlu, ClsAddi, ClsLdi, ClsLd, ClsSt, ClsBr, ClsHalt
  } op_class_e;

  typedef struct packed {
    logic [4:0] opcode;
    logic       gra, grb, grc, rin, rout, baout;
    logic       pcin, irin, marin, mdrin, yin, zin, conin, hiin, loin;
    logic       pcout, mdrout, zlowout, zhighout, cout, hiout, loout;
    logic       read, write, incpc, run;
  } ctrl_t;

  // Undefined opcodes collapse to NOP so they fall straight back to fetch.
  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OpLd:                      cls = ClsLd;
      OpLdi:                     cls = ClsLdi;
      OpSt:                      cls = ClsSt;
      OpAdd, OpSub, OpAnd, OpOr: cls = ClsAlu;
      OpAddi:                    cls = ClsAddi;
      OpBr: begin
`ifdef CU_BRANCH_EN
        cls = ClsBr;
`else
        cls = ClsNop;
`endif
      end
      OpHalt:                    cls = ClsHalt;
      default:                   cls = ClsNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/CON flow in, control strobes flow out.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic [4:0]  opcode;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin, HIin, LOin;
  logic PCout, MDRout, Zlowout, Zhighout, Cout, HIout, LOout;
  logic Read, Write, IncPC, Run;

  modport master (
    input  IR, CON,
    output opcode, Gra, Grb, Grc, Rin, Rout, BAout,
           PCin, IRin, MARin, MDRin, Yin, Zin, CONin, HIin, LOin,
           PCout, MDRout, Zlowout, Zhighout, Cout, HIout, LOout,
           Read, Write, IncPC, Run
  );

  modport slave (
    output IR, CON,
    input  opcode, Gra, Grb, Grc, Rin, Rout, BAout,
           PCin, IRin, MARin, MDRin, Yin, Zin, CONin, HIin, LOin,
           PCout, MDRout, Zlowout, Zhighout, Cout, HIout, LOout,
           Read, Write, IncPC, Run
  );
endinterface

// File: rtl/control_decode.sv
// Combinational control-word decode from FSM state, instruction class and CON.
// Branch behaviour depends on CU_BRANCH_EN through the instruction class.
module control_decode
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  op_class_e  cls_i,
  input  logic [4:0] ir_op_i,
  input  logic       con_i,
  output ctrl_t      ctrl_o
);

  // Moore decode: anything not set for a state stays at zero.
  always_comb begin
    ctrl_o     = '0;
    ctrl_o.run = 1'b1;
    case (state_i)
      StT0: begin
        ctrl_o.pcout = 1'b1; ctrl_o.marin = 1'b1; ctrl_o.incpc = 1'b1; ctrl_o.zin = 1'b1;
      end
      StT1: begin
        ctrl_o.zlowout = 1'b1; ctrl_o.pcin = 1'b1; ctrl_o.read = 1'b1; ctrl_o.mdrin = 1'b1;
      end
      StT2: begin
        ctrl_o.mdrout = 1'b1; ctrl_o.irin = 1'b1;
      end
      StT3: begin
        case (cls_i)
          ClsAlu, ClsAddi: begin
            ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.yin = 1'b1;
          end
          ClsLdi, ClsLd, ClsSt: begin
            ctrl_o.grb = 1'b1; ctrl_o.baout = 1'b1; ctrl_o.yin = 1'b1;
          end
          ClsBr: begin
            ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.conin = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        case (cls_i)
          ClsAlu: begin
            ctrl_o.grc = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.zin = 1'b1; ctrl_o.opcode = ir_op_i;
          end
          // Immediate and effective-address forms all add C to Y.
          ClsAddi, ClsLdi, ClsLd, ClsSt: begin
            ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; ctrl_o.opcode = OpAdd;
          end
          ClsBr: begin
            ctrl_o.pcout = 1'b1; ctrl_o.yin = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        case (cls_i)
          ClsAlu, ClsAddi, ClsLdi: begin
            ctrl_o.zlowout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1;
          end
          ClsLd, ClsSt: begin
            ctrl_o.zlowout = 1'b1; ctrl_o.marin = 1'b1;
          end
          ClsBr: begin
            ctrl_o.cout = 1'b1; ctrl_o.zin = 1'b1; ctrl_o.opcode = OpAdd;
          end
          default: ;
        endcase
      end
      StT6: begin
        case (cls_i)
          ClsLd: begin
            ctrl_o.read = 1'b1; ctrl_o.mdrin = 1'b1;
          end
          ClsSt: begin
            ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.mdrin = 1'b1;
          end
          // Branch target only lands in PC when the condition holds.
          ClsBr: begin
            ctrl_o.zlowout = con_i; ctrl_o.pcin = con_i;
          end
          default: ;
        endcase
      end
      StT7: begin
        case (cls_i)
          ClsLd: begin
            ctrl_o.mdrout = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1;
          end
          ClsSt: ctrl_o.write = 1'b1;
          default: ;
        endcase
      end
      StHlt:   ctrl_o.run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: state register and next-state sequencing; output
// decode lives in control_decode. Feature macro: CU_BRANCH_EN.
module control_unit (
  input logic             Clock,
  input logic             clear,
  control_unit_if.master  cu_bus
);
  import cpu_pkg::*;

  state_e    state_q, state_d;
  op_class_e cls;
  ctrl_t     ctrl;
  logic      unused_ir;

  assign cls       = op_class(cu_bus.IR[31:27]);
  assign unused_ir = ^cu_bus.IR[26:0];

  // Next state: fetch T0-T2, then the instruction class picks the path length.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  state_d = StT2;
      StT2: begin
        case (cls)
          ClsNop:  state_d = StT0;
          ClsHalt: state_d = StHlt;
          default: state_d = StT3;
        endcase
      end
      StT3:  state_d = StT4;
      StT4:  state_d = StT5;
      StT5:  state_d = (cls inside {ClsLd, ClsSt, ClsBr}) ? StT6 : StT0;
      StT6:  state_d = (cls == ClsBr) ? StT0 : StT7;
      StT7:  state_d = StT0;
      StHlt: state_d = StHlt;
      default: state_d = StRst;
    endcase
  end

  // State register; clear takes effect immediately.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= StRst;
    else       state_q <= state_d;
  end

  control_decode u_decode (
    .state_i (state_q),
    .cls_i   (cls),
    .ir_op_i (cu_bus.IR[31:27]),
    .con_i   (cu_bus.CON),
    .ctrl_o  (ctrl)
  );

  assign cu_bus.opcode   = ctrl.opcode;
  assign cu_bus.Gra      = ctrl.gra;
  assign cu_bus.Grb      = ctrl.grb;
  assign cu_bus.Grc      = ctrl.grc;
  assign cu_bus.Rin      = ctrl.rin;
  assign cu_bus.Rout     = ctrl.rout;
  assign cu_bus.BAout    = ctrl.baout;
  assign cu_bus.PCin     = ctrl.pcin;
  assign cu_bus.IRin     = ctrl.irin;
  assign cu_bus.MARin    = ctrl.marin;
  assign cu_bus.MDRin    = ctrl.mdrin;
  assign cu_bus.Yin      = ctrl.yin;
  assign cu_bus.Zin      = ctrl.zin;
  assign cu_bus.CONin    = ctrl.conin;
  assign cu_bus.HIin     = ctrl.hiin;
  assign cu_bus.LOin     = ctrl.loin;
  assign cu_bus.PCout    = ctrl.pcout;
  assign cu_bus.MDRout   = ctrl.mdrout;
  assign cu_bus.Zlowout  = ctrl.zlowout;
  assign cu_bus.Zhighout = ctrl.zhighout;
  assign cu_bus.Cout     = ctrl.cout;
  assign cu_bus.HIout    = ctrl.hiout;
  assign cu_bus.LOout    = ctrl.loout;
  assign cu_bus.Read     = ctrl.read;
  assign cu_bus.Write    = ctrl.write;
  assign cu_bus.IncPC    = ctrl.incpc;
  assign cu_bus.Run      = ctrl.run;

endmodule
